// File: rtl/seq_divider_if.sv
`default_nettype none
// seq_divider_if: request/result handshake bundle for seq_divider.
// Rev 1.0
interface seq_divider_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// seq_divider: unsigned restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Rev 1.0
module seq_divider #(
  parameter int N = 32
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  seq_divider_if.slave  dif
);
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     qreg_q, qreg_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [N:0]       trial;
  logic             bit_new;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qreg_d  = qreg_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    trial   = {rem_q, qreg_q[N-1]};
    bit_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (dif.in_valid) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (dif.divisor == '0) begin
            dbz_d   = 1'b1;
            qreg_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else if (dif.dividend[2*N-1:N] >= dif.divisor) begin
            ovf_d   = 1'b1;
            qreg_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = dif.dividend[2*N-1:N];
            qreg_d  = dif.dividend[N-1:0];
            dvs_d   = dif.divisor;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // rem < dvs keeps the N-bit difference exact when trial >= dvs
        if (trial >= {1'b0, dvs_q}) begin
          rem_d   = trial[N-1:0] - dvs_q;
          bit_new = 1'b1;
        end else begin
          rem_d   = trial[N-1:0];
        end
        qreg_d = {qreg_q[N-2:0], bit_new};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (dif.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      qreg_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qreg_q  <= qreg_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dif.in_ready    = (state_q == IDLE);
  assign dif.out_valid   = (state_q == DONE);
  assign dif.quotient    = qreg_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;
  assign dif.overflow    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// tb_seq_divider: directed and random checks of seq_divider at N=8.
// Rev 1.0
module tb_seq_divider;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and hold in_valid through one rising edge; waits (bounded) for in_ready.
  task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv, output bit ok);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = bus.in_ready;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count rising edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}
        !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d dbz=%b ovf=%b, need rdy=1 vld=0 q=0 r=0 dbz=0 ovf=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_normal();
    bit ok;
    int edges;
    issue(16'd1000, 8'd37, ok);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL normal_early_valid: got out_valid=%b right after accept, need 0", bus.out_valid);
    end
    wait_valid(edges);
    total++;
    if (edges !== 9) begin
      bad++;
      $display("FAIL normal_latency: got %0d cycles, need 9", edges);
    end
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {8'd27, 8'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL normal_1000_37: got q=%0d r=%0d dbz=%b ovf=%b, need q=27 r=1 dbz=0 ovf=0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
    end
    consume();
  endtask

  task automatic test_max();
    bit ok;
    int edges;
    issue(16'hFE01, 8'd255, ok);
    wait_valid(edges);
    total++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.overflow} !== {1'b1, 8'd255, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL max_fe01_255: got vld=%b q=%0d r=%0d ovf=%b, need vld=1 q=255 r=0 ovf=0",
               bus.out_valid, bus.quotient, bus.remainder, bus.overflow);
    end
    consume();
    issue(16'h00FF, 8'd1, ok);
    wait_valid(edges);
    total++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.overflow} !== {1'b1, 8'd255, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL max_00ff_1: got vld=%b q=%0d r=%0d ovf=%b, need vld=1 q=255 r=0 ovf=0",
               bus.out_valid, bus.quotient, bus.remainder, bus.overflow);
    end
    consume();
  endtask

  task automatic test_errors();
    bit ok;
    issue(16'h2000, 8'd20, ok);
    total++;
    if ({bus.out_valid, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder}
        !== {1'b1, 1'b1, 1'b0, 8'hFF, 8'd0}) begin
      bad++;
      $display("FAIL overflow_path: got vld=%b ovf=%b dbz=%b q=%h r=%0d, need vld=1 ovf=1 dbz=0 q=ff r=0",
               bus.out_valid, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    consume();
    issue(16'h1234, 8'd0, ok);
    total++;
    if ({bus.out_valid, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder}
        !== {1'b1, 1'b0, 1'b1, 8'hFF, 8'd0}) begin
      bad++;
      $display("FAIL div_by_zero_path: got vld=%b ovf=%b dbz=%b q=%h r=%0d, need vld=1 ovf=0 dbz=1 q=ff r=0",
               bus.out_valid, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    int unstable;
    issue(16'd1000, 8'd37, ok);
    // Move the input bus during BUSY; the captured operands must be unaffected.
    bus.dividend = 16'hFFFF;
    bus.divisor  = 8'd3;
    wait_valid(edges);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !== {1'b1, 1'b0, 8'd27, 8'd1})
        unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles (q=%0d r=%0d), need 0 with q=27 r=1",
               unstable, bus.quotient, bus.remainder);
    end
    consume();
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL release_ready: got rdy=%b vld=%b, need rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    test_back_to_back();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int edges;
    issue(16'd200, 8'd9, ok);
    wait_valid(edges);
    total++;
    if ({ok, bus.out_valid, bus.quotient, bus.remainder} !== {1'b1, 1'b1, 8'd22, 8'd2}) begin
      bad++;
      $display("FAIL back_to_back_200_9: got ok=%b vld=%b q=%0d r=%0d, need ok=1 vld=1 q=22 r=2",
               ok, bus.out_valid, bus.quotient, bus.remainder);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int edges;
    issue(16'd1000, 8'd37, ok);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_async: got vld=%b rdy=%b, need vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_no_result: got out_valid=%b after abort, need 0", bus.out_valid);
    end
    issue(16'd500, 8'd7, ok);
    wait_valid(edges);
    total++;
    if ({bus.out_valid, bus.quotient, bus.remainder} !== {1'b1, 8'd71, 8'd3}) begin
      bad++;
      $display("FAIL after_reset_500_7: got vld=%b q=%0d r=%0d, need vld=1 q=71 r=3",
               bus.out_valid, bus.quotient, bus.remainder);
    end
    consume();
  endtask

  task automatic test_random();
    bit ok;
    int edges;
    logic [2*N-1:0] dd;
    logic [N-1:0]   dv;
    logic [N-1:0]   eq, er;
    logic           edbz, eovf;
    for (int i = 0; i < 2000; i++) begin
      dd = 16'($urandom);
      dv = 8'($urandom);
      if (i % 50 == 0) dv = 8'd0;
      if (dv != 8'd0 && (i % 4) != 0) dd[15:8] = dd[15:8] % dv;
      edbz = 1'b0;
      eovf = 1'b0;
      if (dv == 8'd0) begin
        edbz = 1'b1; eq = 8'hFF; er = 8'd0;
      end else if (dd[15:8] >= dv) begin
        eovf = 1'b1; eq = 8'hFF; er = 8'd0;
      end else begin
        eq = 8'(dd / {8'd0, dv});
        er = 8'(dd % {8'd0, dv});
      end
      issue(dd, dv, ok);
      wait_valid(edges);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      total++;
      if ({ok, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}
          !== {1'b1, 1'b1, eq, er, edbz, eovf}) begin
        bad++;
        $display("FAIL random_%0d %0d/%0d: got vld=%b q=%0d r=%0d dbz=%b ovf=%b, need q=%0d r=%0d dbz=%b ovf=%b",
                 i, dd, dv, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                 eq, er, edbz, eovf);
      end
      consume();
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_normal();
    test_max();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
